// File: rtl/ps2_kbd_if.sv
// rtl/ps2_kbd_if.sv - Wishbone slave bundle for the PS/2 keyboard port
interface if_wb;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_i;
   logic [31:0] dat_o;
   logic        ack;

   modport master (
      output cyc, stb, we, adr, sel, dat_i,
      input  dat_o, ack
   );

   modport slave (
      input  cyc, stb, we, adr, sel, dat_i,
      output dat_o, ack
   );
endinterface

// File: rtl/ps2_kbd.sv
// rtl/ps2_kbd.sv - PS/2 keyboard receiver with byte FIFO, Wishbone registers and level interrupt
// Optional ps2_clk glitch filter enabled by defining PS2_KBD_FILTER_EN.
module ps2_kbd #(
   parameter int CLKFREQ    = 10_000_000,
   parameter int DEPTH      = 16,
   parameter int FILTER_LEN = 4
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   if_wb.slave   bus,
   input  logic  ps2_clk,
   input  logic  ps2_data,
   output logic  interrupt
);

   localparam int AW       = $clog2(DEPTH);
   localparam int CW       = AW + 1;
   localparam int TO_LIMIT = CLKFREQ / 1000;
   localparam int TW       = $clog2(TO_LIMIT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TO_LIMIT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic [1:0] clk_sync;
   logic [1:0] data_sync;
   logic       sclk;
   logic       sdata;
   logic       edge_clk;
   logic       prev_clk;
   logic       fall;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         clk_sync  <= 2'b11;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   assign sclk  = clk_sync[1];
   assign sdata = data_sync[1];

`ifdef PS2_KBD_FILTER_EN
   localparam int FW = $clog2(FILTER_LEN + 1);
   logic          filt_clk;
   logic [FW-1:0] filt_cnt;

   // The filtered clock follows sclk only after FILTER_LEN consecutive disagreeing samples.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
      end else if (sclk == filt_clk) begin
         filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
         filt_clk <= sclk;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + 1'b1;
      end
   end

   assign edge_clk = filt_clk;
`else
   assign edge_clk = sclk;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) prev_clk <= 1'b1;
      else         prev_clk <= edge_clk;
   end

   assign fall = prev_clk & ~edge_clk;

   state_t        state;
   logic [2:0]    bitcnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] timer;

   logic [CW-1:0] count;
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [7:0]    mem [DEPTH];
   logic          full;
   logic          not_empty;

   logic          acc;
   logic          rd;
   logic          wr;
   logic [1:0]    reg_sel;
   logic          pop;
   logic          push;
   logic          stop_ev;
   logic          to_ev;
   logic          par_ok;
   logic          ferr_ev;
   logic          perr_ev;
   logic          ovf_ev;
   logic [2:0]    sts_clr;

   logic          ovf;
   logic          perr;
   logic          ferr;
   logic          ie;
   logic [8:0]    cnt_ext;
   logic [7:0]    cnt8;
   logic [31:0]   rdata;

   assign full      = (count == CW'(DEPTH));
   assign not_empty = (count != '0);

   assign acc     = bus.cyc & bus.stb & ~bus.ack;
   assign rd      = acc & ~bus.we;
   assign wr      = acc & bus.we;
   assign reg_sel = bus.adr[3:2];
   assign pop     = rd & (reg_sel == 2'd0) & not_empty;
   assign sts_clr = (wr && reg_sel == 2'd1) ? bus.dat_i[4:2] : 3'b000;

   // Frame outcome is resolved on the stop edge; a same-cycle pop frees room for the push.
   assign stop_ev = (state == S_STOP) & fall;
   assign to_ev   = (state != S_IDLE) & ~fall & (timer == TO_LAST);
   assign par_ok  = ^{shreg, par_bit};
   assign ferr_ev = (stop_ev & ~sdata) | to_ev;
   assign perr_ev = stop_ev & sdata & ~par_ok;
   assign ovf_ev  = stop_ev & sdata & par_ok & full & ~pop;
   assign push    = stop_ev & sdata & par_ok & (~full | pop);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state   <= S_IDLE;
         bitcnt  <= '0;
         shreg   <= '0;
         par_bit <= 1'b0;
         timer   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fall && !sdata) begin
                  state  <= S_DATA;
                  bitcnt <= '0;
               end
            end
            S_DATA: begin
               if (fall) begin
                  shreg  <= {sdata, shreg[7:1]};
                  bitcnt <= bitcnt + 1'b1;
                  if (bitcnt == 3'd7) state <= S_PARITY;
               end
            end
            S_PARITY: begin
               if (fall) begin
                  par_bit <= sdata;
                  state   <= S_STOP;
               end
            end
            S_STOP: begin
               if (fall) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         if (state == S_IDLE || fall) begin
            timer <= '0;
         end else if (timer == TO_LAST) begin
            timer <= '0;
            state <= S_IDLE;
         end else begin
            timer <= timer + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wptr] <= shreg;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count <= '0;
         wptr  <= '0;
         rptr  <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
      end
   end

   // Set beats clear when both land on the same edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ovf  <= 1'b0;
         perr <= 1'b0;
         ferr <= 1'b0;
      end else begin
         ovf  <= (ovf  & ~sts_clr[0]) | ovf_ev;
         perr <= (perr & ~sts_clr[1]) | perr_ev;
         ferr <= (ferr & ~sts_clr[2]) | ferr_ev;
      end
   end

   assign cnt_ext = 9'(count);
   assign cnt8    = cnt_ext[8] ? 8'hFF : cnt_ext[7:0];

   always_comb begin
      rdata = '0;
      case (reg_sel)
         2'd0: if (not_empty) rdata[7:0] = mem[rptr];
         2'd1: rdata = {16'h0000, cnt8, 3'b000, ferr, perr, ovf, full, not_empty};
         2'd2: rdata[0] = ie;
         default: rdata = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         bus.ack   <= 1'b0;
         bus.dat_o <= '0;
         ie        <= 1'b0;
      end else begin
         bus.ack <= acc;
         if (acc) bus.dat_o <= bus.we ? 32'h0 : rdata;
         if (wr && reg_sel == 2'd2) ie <= bus.dat_i[0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) interrupt <= 1'b0;
      else         interrupt <= ie & not_empty;
   end

endmodule

// File: tb/tb_ps2_kbd.sv
// tb/tb_ps2_kbd.sv - scoreboard bench for ps2_kbd; filter test selected by PS2_KBD_FILTER_EN
module tb_ps2_kbd;
   localparam int CLKFREQ = 1_000_000;
   localparam int DEPTH   = 16;
   localparam int HALF    = 25;

   logic clk      = 1'b0;
   logic rst_n    = 1'b0;
   logic ps2_clk  = 1'b1;
   logic ps2_data = 1'b1;
   logic interrupt;

   if_wb bus ();

   ps2_kbd #(
      .CLKFREQ    (CLKFREQ),
      .DEPTH      (DEPTH),
      .FILTER_LEN (4)
   ) dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .bus       (bus),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .interrupt (interrupt)
   );

   always #5 clk = ~clk;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q[$];
   bit         m_ovf, m_perr, m_ferr;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_status();
      logic [31:0] s;
      s        = '0;
      s[15:8]  = 8'(exp_q.size());
      s[0]     = (exp_q.size() != 0);
      s[1]     = (exp_q.size() == DEPTH);
      s[2]     = m_ovf;
      s[3]     = m_perr;
      s[4]     = m_ferr;
      return s;
   endfunction

   task automatic wb_cycle(input logic we, input logic [1:0] idx, input logic [31:0] wdata,
                           output logic [31:0] rdata);
      bit got;
      @(negedge clk);
      bus.cyc   = 1'b1;
      bus.stb   = 1'b1;
      bus.we    = we;
      bus.adr   = {28'h0, idx, 2'b00};
      bus.sel   = 4'hF;
      bus.dat_i = wdata;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (bus.ack) begin
            got = 1'b1;
            break;
         end
      end
      rdata   = bus.dat_o;
      bus.cyc = 1'b0;
      bus.stb = 1'b0;
      bus.we  = 1'b0;
      if (!got) check("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic wb_write(input logic [1:0] idx, input logic [31:0] wdata);
      logic [31:0] dummy;
      wb_cycle(1'b1, idx, wdata, dummy);
      if (idx == 2'd1) begin
         if (wdata[2]) m_ovf  = 1'b0;
         if (wdata[3]) m_perr = 1'b0;
         if (wdata[4]) m_ferr = 1'b0;
      end
   endtask

   task automatic check_status(input string tag);
      logic [31:0] d;
      wb_cycle(1'b0, 2'd1, 32'h0, d);
      check(tag, d, exp_status());
   endtask

   task automatic check_data(input string tag);
      logic [31:0] d;
      logic [31:0] e;
      wb_cycle(1'b0, 2'd0, 32'h0, d);
      e = (exp_q.size() != 0) ? {24'h0, exp_q.pop_front()} : 32'h0;
      check(tag, d, e);
   endtask

   function automatic logic odd_par(input logic [7:0] b);
      return ~(^b);
   endfunction

   // Drives the first nbits of start/data/parity/stop; only complete frames update the model.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int nbits);
      logic [10:0] bits;
      bits = {stop, par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      ps2_data = 1'b1;
      if (nbits == 11) begin
         if (!stop)                    m_ferr = 1'b1;
         else if (^{b, par} != 1'b1)   m_perr = 1'b1;
         else if (exp_q.size() == DEPTH) m_ovf = 1'b1;
         else                          exp_q.push_back(b);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      bit          seen;
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      bus.adr = '0;   bus.sel = 4'h0; bus.dat_i = '0;
      m_ovf = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", {31'h0, bus.ack}, 32'h0);
      check("rst_dat_o", bus.dat_o, 32'h0);
      check("rst_irq", {31'h0, interrupt}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      check_status("rst_status");
      wb_cycle(1'b0, 2'd2, 32'h0, d);
      check("rst_ctrl", d, 32'h0);

      wb_write(2'd3, 32'hFFFF_FFFF);
      wb_cycle(1'b0, 2'd3, 32'h0, d);
      check("reg3_zero", d, 32'h0);

      send_frame(8'h1C, 1'b0, 1'b1, 11);
      check("status_1c", exp_status(), 32'h0000_0101);
      check_status("status_after_1c");
      check_data("data_1c");
      check_status("status_empty");

      send_frame(8'h1C, 1'b1, 1'b1, 11);
      check_status("status_perr");
      wb_write(2'd1, 32'h08);
      check_status("status_perr_clr");

      for (int i = 1; i <= DEPTH + 1; i++) begin
         send_frame(8'(i), odd_par(8'(i)), 1'b1, 11);
      end
      check_status("status_full_ovf");
      for (int i = 0; i < DEPTH; i++) check_data("data_fifo");
      check_status("status_drained");
      wb_write(2'd1, 32'h1C);
      check_status("status_clr_all");

      send_frame(8'h05, 1'b0, 1'b1, 4);
      repeat (2 * CLKFREQ / 1000) @(negedge clk);
      m_ferr = 1'b1;
      check_status("status_timeout");
      wb_write(2'd1, 32'h10);
      send_frame(8'h5A, odd_par(8'h5A), 1'b1, 11);
      check_status("status_5a");
      check_data("data_5a");

      send_frame(8'h3C, odd_par(8'h3C), 1'b0, 11);
      check_status("status_stop_err");
      wb_write(2'd1, 32'h10);

      wb_write(2'd2, 32'h1);
      wb_cycle(1'b0, 2'd2, 32'h0, d);
      check("ctrl_ie", d, 32'h1);
      send_frame(8'h76, odd_par(8'h76), 1'b1, 10);
      check("irq_idle", {31'h0, interrupt}, 32'h0);
      @(negedge clk);
      ps2_data = 1'b1;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         if (interrupt) begin
            seen = 1'b1;
            break;
         end
      end
      check("irq_rise", {31'h0, seen}, 32'h1);
      exp_q.push_back(8'h76);
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      check_data("data_76");
      check("irq_at_ack", {31'h0, interrupt}, 32'h1);
      @(posedge clk);
      #1;
      check("irq_fall", {31'h0, interrupt}, 32'h0);
      check_data("data_empty");
      check_status("status_after_76");

`ifdef PS2_KBD_FILTER_EN
      @(negedge clk);
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      repeat (2) @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (CLKFREQ / 1000 + 200) @(negedge clk);
      check_status("status_glitch_filtered");
`else
      @(negedge clk);
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      @(negedge clk);
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (CLKFREQ / 1000 + 200) @(negedge clk);
      m_ferr = 1'b1;
      check_status("status_glitch_edge");
      wb_write(2'd1, 32'h10);
`endif
      send_frame(8'hF0, odd_par(8'hF0), 1'b1, 11);
      check_status("status_f0");
      check_data("data_f0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
